// File: rtl/i2c_shift_sequencer.sv
// Bit-level I2C byte sequencer that drives an external universal shift register.
// Optional target clock stretching: define I2C_SEQ_CLK_STRETCH_EN (adds the scl_i input).
module i2c_shift_sequencer #(
   parameter int unsigned N        = 8,
   parameter int unsigned HALF_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic                  dir,
   input  logic [N-1:0]          tx_byte,
   input  logic                  ack_send,
   input  logic [N-1:0]          sr_q,
   output logic [$clog2(N)-1:0]  sr_s,
   output logic [N-1:0]          sr_d,
   output logic                  sr_msb_in,
   output logic                  sr_lsb_in,
   output logic                  scl_o,
   output logic                  sda_oe,
   input  logic                  sda_i,
`ifdef I2C_SEQ_CLK_STRETCH_EN
   input  logic                  scl_i,
`endif
   output logic                  done_valid,
   output logic [N-1:0]          rx_byte,
   output logic                  ack_bit,
   output logic                  busy
);

   localparam int unsigned SW = $clog2(N);
   localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DW = $clog2(HALF_DIV) + 1;

   localparam logic [SW-1:0] SelHold  = SW'(0);
   localparam logic [SW-1:0] SelLoad  = SW'(1);
   localparam logic [SW-1:0] SelShift = SW'(3);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StBitLo,
      StBitHi,
      StAckLo,
      StAckHi,
      StDone
   } state_e;

   state_e        state_q;
   logic [DW-1:0] div_q;
   logic [BW-1:0] bit_q;
   logic          dir_q;
   logic [N-1:0]  tx_q;
   logic          ack_send_q;

   logic          div_hold;
   logic          div_last;

`ifdef I2C_SEQ_CLK_STRETCH_EN
   logic hi_phase;
   // A target holding SCL low freezes the high-phase divider until SCL is seen released.
   assign hi_phase = (state_q == StBitHi) || (state_q == StAckHi);
   assign div_hold = hi_phase && !scl_i;
`else
   assign div_hold = 1'b0;
`endif

   assign div_last = !div_hold && (div_q == DW'(HALF_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         div_q      <= '0;
         bit_q      <= '0;
         dir_q      <= 1'b0;
         tx_q       <= '0;
         ack_send_q <= 1'b0;
         rx_byte    <= '0;
         ack_bit    <= 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_valid) begin
                  dir_q      <= dir;
                  tx_q       <= tx_byte;
                  ack_send_q <= ack_send;
                  state_q    <= StLoad;
               end
            end
            StLoad: begin
               div_q   <= '0;
               bit_q   <= '0;
               state_q <= StBitLo;
            end
            StBitLo: begin
               if (div_last) begin
                  div_q   <= '0;
                  state_q <= StBitHi;
               end else begin
                  div_q <= div_q + DW'(1);
               end
            end
            StBitHi: begin
               if (div_last) begin
                  div_q <= '0;
                  if (bit_q == BW'(N - 1)) begin
                     state_q <= StAckLo;
                  end else begin
                     bit_q   <= bit_q + BW'(1);
                     state_q <= StBitLo;
                  end
               end else if (!div_hold) begin
                  div_q <= div_q + DW'(1);
               end
            end
            StAckLo: begin
               if (div_last) begin
                  div_q   <= '0;
                  state_q <= StAckHi;
               end else begin
                  div_q <= div_q + DW'(1);
               end
            end
            StAckHi: begin
               if (div_last) begin
                  div_q   <= '0;
                  ack_bit <= sda_i;
                  state_q <= StDone;
               end else if (!div_hold) begin
                  div_q <= div_q + DW'(1);
               end
            end
            StDone: begin
               rx_byte <= sr_q;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Outputs decode the registered state; the shift strobe and serial input must see the
   // live divider and SDA level in the final high cycle of each bit.
   always_comb begin
      start_ready = (state_q == StIdle) && rst;
      busy        = (state_q != StIdle);
      done_valid  = (state_q == StDone);
      scl_o       = !((state_q == StBitLo) || (state_q == StAckLo));
      sr_msb_in   = 1'b0;
      sr_s        = SelHold;
      sr_d        = '0;
      sr_lsb_in   = 1'b0;
      sda_oe      = 1'b0;
      case (state_q)
         StLoad: begin
            sr_s = SelLoad;
            sr_d = dir_q ? '0 : tx_q;
         end
         StBitLo: sda_oe = !dir_q && !sr_q[N-1];
         StBitHi: begin
            sda_oe = !dir_q && !sr_q[N-1];
            if (div_last) begin
               sr_s      = SelShift;
               sr_lsb_in = dir_q && sda_i;
            end
         end
         StAckLo, StAckHi: sda_oe = dir_q && ack_send_q;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_i2c_shift_sequencer.sv
// Self-checking bench for i2c_shift_sequencer: table-driven bytes plus back-to-back,
// mid-byte reset, HALF_DIV=1 and (with I2C_SEQ_CLK_STRETCH_EN) clock stretching.
module tb_i2c_shift_sequencer;

   localparam int N   = 8;
   localparam int H   = 4;
   localparam int LAT = 2 + 2 * H * (N + 1);   // accept-to-DONE cycle, 74
   localparam int BITS_END = 2 + 2 * H * N;    // first ACK_LO cycle, 66

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start_valid = 1'b0;
   logic start_valid1 = 1'b0;
   logic dir = 1'b0;
   logic ack_send = 1'b0;
   logic sda_i = 1'b1;
   logic scl_i = 1'b1;
   logic [N-1:0] tx_byte = '0;

   logic start_ready, sr_msb_in, sr_lsb_in, scl_o, sda_oe, done_valid, ack_bit, busy;
   logic [2:0]   sr_s;
   logic [N-1:0] sr_d, rx_byte;
   logic [N-1:0] sr_q = '0;

   logic start_ready1, sr_msb_in1, sr_lsb_in1, scl_o1, sda_oe1, done_valid1, ack_bit1, busy1;
   logic [2:0]   sr_s1;
   logic [N-1:0] sr_d1, rx_byte1;
   logic [N-1:0] sr_q1 = '0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   i2c_shift_sequencer #(.N(N), .HALF_DIV(H)) dut (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
      .dir(dir), .tx_byte(tx_byte), .ack_send(ack_send), .sr_q(sr_q), .sr_s(sr_s),
      .sr_d(sr_d), .sr_msb_in(sr_msb_in), .sr_lsb_in(sr_lsb_in), .scl_o(scl_o),
      .sda_oe(sda_oe), .sda_i(sda_i),
`ifdef I2C_SEQ_CLK_STRETCH_EN
      .scl_i(scl_i),
`endif
      .done_valid(done_valid), .rx_byte(rx_byte), .ack_bit(ack_bit), .busy(busy)
   );

   i2c_shift_sequencer #(.N(N), .HALF_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .start_valid(start_valid1), .start_ready(start_ready1),
      .dir(dir), .tx_byte(tx_byte), .ack_send(ack_send), .sr_q(sr_q1), .sr_s(sr_s1),
      .sr_d(sr_d1), .sr_msb_in(sr_msb_in1), .sr_lsb_in(sr_lsb_in1), .scl_o(scl_o1),
      .sda_oe(sda_oe1), .sda_i(sda_i),
`ifdef I2C_SEQ_CLK_STRETCH_EN
      .scl_i(1'b1),
`endif
      .done_valid(done_valid1), .rx_byte(rx_byte1), .ack_bit(ack_bit1), .busy(busy1)
   );

   // Downstream universal shift register: 1 = load, 3 = shift left, otherwise hold.
   always @(posedge clk) begin
      case (sr_s)
         3'd1: sr_q <= sr_d;
         3'd3: sr_q <= {sr_q[N-2:0], sr_lsb_in};
         default: ;
      endcase
      case (sr_s1)
         3'd1: sr_q1 <= sr_d1;
         3'd3: sr_q1 <= {sr_q1[N-2:0], sr_lsb_in1};
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic         dir;
      logic [N-1:0] tx;
      logic         ack_send;
      logic [N-1:0] pat;        // byte the target presents on SDA (RX)
      logic         tgt_ack;    // SDA level during bit 9
      logic [N-1:0] exp_oe;     // sda_oe per bit, MSB first
      logic         exp_ack_oe;
      logic [N-1:0] exp_rx;
      logic         exp_ack;
   } vec_t;

   vec_t vecs[4];

   // One byte from IDLE; s_len cycles of SCL held low starting at cycle s_at.
   task automatic run_vec(input string tag, input vec_t v, input int s_at, input int s_len);
      int e, k, done_cnt, done_cyc, scl_err, oe_err, ack_oe_err, busy_err, rdy_err;
      int shifts, loads;
      logic [N-1:0] obs_oe, load_d;
      logic exp_scl;
      done_cnt = 0; done_cyc = -1; scl_err = 0; oe_err = 0; ack_oe_err = 0;
      busy_err = 0; rdy_err = 0; shifts = 0; loads = 0; obs_oe = '0; load_d = '0;
      for (int c = 0; c <= LAT + 1 + s_len; c++) begin
         @(negedge clk);
         if (c < s_at) e = c;
         else if (c < s_at + s_len) e = s_at;
         else e = c - s_len;
         start_valid = (c == 0);
         if (c == 0) begin
            dir = v.dir;
            tx_byte = v.tx;
            ack_send = v.ack_send;
         end
         scl_i = !(c >= s_at && c < s_at + s_len);
         if (e >= 2 && e < BITS_END) sda_i = v.pat[N - 1 - (e - 2) / (2 * H)];
         else if (e >= BITS_END && e < LAT) sda_i = v.tgt_ack;
         else sda_i = 1'b1;
         #1;
         exp_scl = (e >= 2 && e < LAT) ? (((e - 2) / H) % 2 == 1) : 1'b1;
         if (scl_o !== exp_scl) scl_err++;
         if (e >= 2 && e < BITS_END) begin
            k = (e - 2) / (2 * H);
            if (sda_oe !== v.exp_oe[N - 1 - k]) oe_err++;
            if ((e - 2) % (2 * H) == 0) obs_oe[N - 1 - k] = sda_oe;
         end else if (e >= BITS_END && e < LAT) begin
            if (sda_oe !== v.exp_ack_oe) ack_oe_err++;
         end else if (sda_oe !== 1'b0) begin
            oe_err++;
         end
         if (busy !== (e >= 1 && e <= LAT)) busy_err++;
         if (start_ready !== (e == 0 || e > LAT)) rdy_err++;
         if (done_valid === 1'b1) begin
            done_cnt++;
            done_cyc = c;
         end
         if (sr_s == 3'd3) shifts++;
         if (sr_s == 3'd1) begin
            loads++;
            load_d = sr_d;
         end
      end
      start_valid = 1'b0;
      check({tag, " oe_bits"}, 32'(obs_oe), 32'(v.exp_oe));
      check({tag, " oe_steady"}, 32'(oe_err), 0);
      check({tag, " ack_oe"}, 32'(ack_oe_err), 0);
      check({tag, " scl"}, 32'(scl_err), 0);
      check({tag, " done_cnt"}, 32'(done_cnt), 1);
      check({tag, " done_cyc"}, 32'(done_cyc), 32'(LAT + s_len));
      check({tag, " busy"}, 32'(busy_err), 0);
      check({tag, " ready"}, 32'(rdy_err), 0);
      check({tag, " shifts"}, 32'(shifts), 32'(N));
      check({tag, " loads"}, 32'(loads), 1);
      check({tag, " load_d"}, 32'(load_d), v.dir ? 32'd0 : 32'(v.tx));
      check({tag, " rx_byte"}, 32'(rx_byte), 32'(v.exp_rx));
      check({tag, " ack_bit"}, 32'(ack_bit), 32'(v.exp_ack));
   endtask

   initial begin
      int dcnt, d0, d1, err, sh, dc;
      logic oe_a, oe_b;
      logic [N-1:0] obs;

      //          dir   tx     ack pat    tgt  exp_oe ackoe exp_rx ack
      vecs[0] = '{1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{1'b1, 8'h00, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0};
      vecs[2] = '{1'b0, 8'h01, 1'b0, 8'hFF, 1'b1, 8'hFE, 1'b0, 8'h00, 1'b1};
      vecs[3] = '{1'b1, 8'hFF, 1'b0, 8'hC3, 1'b1, 8'h00, 1'b0, 8'hC3, 1'b1};

      // Reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("ready_in_reset", 32'(start_ready), 0);
      rst = 1'b1;
      #1;
      check("rst scl_o", 32'(scl_o), 1);
      check("rst sda_oe", 32'(sda_oe), 0);
      check("rst sr_s", 32'(sr_s), 0);
      check("rst sr_d", 32'(sr_d), 0);
      check("rst sr_lsb_in", 32'(sr_lsb_in), 0);
      check("rst done_valid", 32'(done_valid), 0);
      check("rst rx_byte", 32'(rx_byte), 0);
      check("rst ack_bit", 32'(ack_bit), 1);
      check("rst busy", 32'(busy), 0);
      check("rst start_ready", 32'(start_ready), 1);

      for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0, 0);

      // Back-to-back: start_valid held, FF then 00; DONE at 74 and 149.
      dcnt = 0; d0 = -1; d1 = -1; err = 0; oe_a = 1'bx; oe_b = 1'bx;
      for (int c = 0; c <= 2 * LAT + 3; c++) begin
         @(negedge clk);
         start_valid = (c <= LAT + 1);
         dir = 1'b0;
         tx_byte = (c == 0) ? 8'hFF : 8'h00;
         sda_i = 1'b1;
         #1;
         if (done_valid === 1'b1) begin
            if (dcnt == 0) d0 = c;
            else d1 = c;
            dcnt++;
         end
         if (start_ready !== (c == 0 || c == LAT + 1 || c >= 2 * LAT + 2)) err++;
         if (c == 2) oe_a = sda_oe;
         if (c == LAT + 3) oe_b = sda_oe;
      end
      start_valid = 1'b0;
      check("b2b done_cnt", 32'(dcnt), 2);
      check("b2b done0", 32'(d0), 32'(LAT));
      check("b2b done1", 32'(d1), 32'(2 * LAT + 1));
      check("b2b ready", 32'(err), 0);
      check("b2b oe_byte0", 32'(oe_a), 0);
      check("b2b oe_byte1", 32'(oe_b), 1);

      // Reset in bit 4 of TX A5 (bit 4 is 0, so SDA is being pulled low).
      for (int c = 0; c <= 37; c++) begin
         @(negedge clk);
         start_valid = (c == 0);
         dir = 1'b0;
         tx_byte = 8'hA5;
         sda_i = 1'b1;
         rst = (c != 36);
         #1;
         if (c == 36) begin
            check("abort pre scl", 32'(scl_o), 0);
            check("abort pre sda_oe", 32'(sda_oe), 1);
         end
      end
      check("abort scl_o", 32'(scl_o), 1);
      check("abort sda_oe", 32'(sda_oe), 0);
      check("abort busy", 32'(busy), 0);
      check("abort done", 32'(done_valid), 0);
      check("abort ready", 32'(start_ready), 1);
      start_valid = 1'b0;
      err = 0;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (done_valid !== 1'b0 || busy !== 1'b0) err++;
      end
      check("abort quiet", 32'(err), 0);
      run_vec("after_abort", vecs[0], 0, 0);

      // HALF_DIV=1, TX 81: DONE at cycle 20, SCL toggling every cycle.
      err = 0; sh = 0; dcnt = 0; dc = -1; obs = '0;
      for (int c = 0; c <= 21; c++) begin
         @(negedge clk);
         start_valid1 = (c == 0);
         dir = 1'b0;
         tx_byte = 8'h81;
         sda_i = 1'b0;
         #1;
         if (c >= 2 && c < 20 && scl_o1 !== ((c - 2) % 2 == 1)) err++;
         if (c >= 2 && c < 18 && (c - 2) % 2 == 0) obs[N - 1 - (c - 2) / 2] = sda_oe1;
         if (sr_s1 == 3'd3) sh++;
         if (done_valid1 === 1'b1) begin
            dcnt++;
            dc = c;
         end
      end
      start_valid1 = 1'b0;
      check("div1 done_cyc", 32'(dc), 20);
      check("div1 done_cnt", 32'(dcnt), 1);
      check("div1 scl", 32'(err), 0);
      check("div1 oe_bits", 32'(obs), 32'h7E);
      check("div1 shifts", 32'(sh), 8);
      check("div1 ack_bit", 32'(ack_bit1), 0);

`ifdef I2C_SEQ_CLK_STRETCH_EN
      // SCL held low 10 cycles from the start of bit 2 BIT_HI (cycle 22): DONE at 84.
      run_vec("stretch", vecs[1], 22, 10);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
